position_poller: RTL

Initiator side of the position soc_p/eoc_p handshake. While enabled, it repeatedly requests a new position from the position-update unit and captures the returned 8-bit x/y. It also computes the per-step displacement and flags a stalled or unresponsive update unit. It sits between the position-update unit and downstream display/logging logic.

---
 rtl/position_poller_pkg.sv | 44 ++++
 rtl/position_poller_displacement_calc.sv | 31 +++
 rtl/position_poller.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/position_poller_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : position_poller_pkg
//  Purpose  : Shared constants and types for the position poller and the
//             position-update unit: position width, FSM state encoding and
//             default timing parameters.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package position_poller_pkg;

   // Position width, shared with the position-update unit.
   localparam int c_POS_W = 8;

   // Width of the per-state cycle counter (covers GAP and TIMEOUT up to 255).
   localparam int c_CNT_W = 8;

   // Width of the saturating stall counter.
   localparam int c_STALL_W = 4;

   // FSM state encoding.
   localparam logic [2:0] c_ST_IDLE    = 3'd0;
   localparam logic [2:0] c_ST_READY   = 3'd1;
   localparam logic [2:0] c_ST_REQ     = 3'd2;
   localparam logic [2:0] c_ST_ACK     = 3'd3;
   localparam logic [2:0] c_ST_CAPTURE = 3'd4;
   localparam logic [2:0] c_ST_GAP     = 3'd5;

   typedef enum logic [2:0] {
      ST_IDLE    = c_ST_IDLE,
      ST_READY   = c_ST_READY,
      ST_REQ     = c_ST_REQ,
      ST_ACK     = c_ST_ACK,
      ST_CAPTURE = c_ST_CAPTURE,
      ST_GAP     = c_ST_GAP
   } state_t;

   // Default timing parameters.
   localparam int unsigned c_GAP_DEFAULT         = 4;
   localparam int unsigned c_STALL_LIMIT_DEFAULT = 3;
   localparam int unsigned c_TIMEOUT_DEFAULT     = 255;

endpackage
`default_nettype wire

// File: rtl/position_poller_displacement_calc.sv
`default_nettype none
// ============================================================================
//  Module   : displacement_calc
//  Purpose  : Combinational displacement between a new and a previous
//             position, modulo 2^c_POS_W, plus an "unchanged" flag.
//  Ports    : x_new, y_new   in   new position
//             x_prev, y_prev in   previous position
//             dx, dy         out  new - previous (wrapping, two's complement)
//             same           out  1 when both coordinates are unchanged
//  Revision : 1.0  initial release
// ============================================================================
module displacement_calc
   import position_poller_pkg::*;
(
   input  logic [c_POS_W-1:0] x_new,
   input  logic [c_POS_W-1:0] y_new,
   input  logic [c_POS_W-1:0] x_prev,
   input  logic [c_POS_W-1:0] y_prev,
   output logic [c_POS_W-1:0] dx,
   output logic [c_POS_W-1:0] dy,
   output logic               same
);

   // Plain unsigned subtraction truncated to c_POS_W bits gives the signed
   // wrap-around displacement.
   assign dx   = x_new - x_prev;
   assign dy   = y_new - y_prev;
   assign same = (x_new == x_prev) && (y_new == y_prev);

endmodule
`default_nettype wire

// File: rtl/position_poller.sv
`default_nettype none
// ============================================================================
//  Module   : position_poller
//  Purpose  : Initiator of the soc_p/eoc_p handshake. Repeatedly requests a
//             position while run is high, captures x/y, computes the step
//             displacement, counts samples and flags stall / timeout.
//  Ports    : clock, reset      in   clock, synchronous active-high reset
//             run               in   polling enable (checked at end of GAP)
//             soc_p             out  start-of-conversion request
//             eoc_p             in   end-of-conversion / idle indicator
//             x, y              in   position from the update unit
//             x_last, y_last    out  last captured position
//             dx, dy            out  displacement of last step
//             sample_valid      out  one-cycle pulse on new sample
//             n_samples         out  saturating sample count
//             stalled           out  position unchanged for STALL_LIMIT steps
//             timeout           out  sticky handshake-abort flag
//  Revision : 1.0  initial release
// ============================================================================
module position_poller
   import position_poller_pkg::*;
#(
   parameter int unsigned GAP         = c_GAP_DEFAULT,
   parameter int unsigned STALL_LIMIT = c_STALL_LIMIT_DEFAULT,
   parameter int unsigned TIMEOUT     = c_TIMEOUT_DEFAULT
)(
   input  logic               clock,
   input  logic               reset,
   input  logic               run,
   output logic               soc_p,
   input  logic               eoc_p,
   input  logic [c_POS_W-1:0] x,
   input  logic [c_POS_W-1:0] y,
   output logic [c_POS_W-1:0] x_last,
   output logic [c_POS_W-1:0] y_last,
   output logic [c_POS_W-1:0] dx,
   output logic [c_POS_W-1:0] dy,
   output logic               sample_valid,
   output logic [7:0]         n_samples,
   output logic               stalled,
   output logic               timeout
);

   // Terminal counts: the counter starts at 0 on state entry, so reaching
   // value N-1 means N cycles have been spent in the state.
   localparam logic [c_CNT_W-1:0]   c_TMO_LAST  = c_CNT_W'(TIMEOUT - 1);
   localparam logic [c_CNT_W-1:0]   c_GAP_LAST  = c_CNT_W'(GAP - 1);
   localparam logic [c_STALL_W-1:0] c_STALL_LIM = c_STALL_W'(STALL_LIMIT);

   state_t                 r_state;
   state_t                 w_next_state;
   logic [c_CNT_W-1:0]     r_cnt;
   logic                   w_abort;
   logic                   w_capture;
   logic                   w_counting;

   logic                   r_soc_p;
   logic [c_POS_W-1:0]     r_x_last;
   logic [c_POS_W-1:0]     r_y_last;
   logic [c_POS_W-1:0]     r_dx;
   logic [c_POS_W-1:0]     r_dy;
   logic                   r_sample_valid;
   logic [7:0]             r_n_samples;
   logic                   r_stalled;
   logic                   r_timeout;
   logic                   r_have_prev;
   logic [c_STALL_W-1:0]   r_stall_cnt;
   logic [c_STALL_W-1:0]   w_stall_next;

   logic [c_POS_W-1:0]     w_dx;
   logic [c_POS_W-1:0]     w_dy;
   logic                   w_same;

   displacement_calc u_disp (
      .x_new  (x),
      .y_new  (y),
      .x_prev (r_x_last),
      .y_prev (r_y_last),
      .dx     (w_dx),
      .dy     (w_dy),
      .same   (w_same)
   );

   // ---------------------------------------------------------------------
   // Next-state logic. A normal handshake transition takes priority over a
   // timeout abort landing on the same cycle.
   // ---------------------------------------------------------------------
   always_comb begin
      w_next_state = r_state;
      w_abort      = 1'b0;
      case (r_state)
         ST_IDLE:    if (run) w_next_state = ST_READY;
         ST_READY:   if (eoc_p) w_next_state = ST_REQ;
                     else if (r_cnt == c_TMO_LAST) w_abort = 1'b1;
         ST_REQ:     if (!eoc_p) w_next_state = ST_ACK;
                     else if (r_cnt == c_TMO_LAST) w_abort = 1'b1;
         ST_ACK:     if (eoc_p) w_next_state = ST_CAPTURE;
                     else if (r_cnt == c_TMO_LAST) w_abort = 1'b1;
         ST_CAPTURE: w_next_state = ST_GAP;
         ST_GAP:     if (r_cnt == c_GAP_LAST) w_next_state = run ? ST_READY : ST_IDLE;
         default:    w_next_state = ST_IDLE;
      endcase
      if (w_abort) w_next_state = ST_IDLE;
   end

   // The result is taken the same cycle eoc_p=1 is seen in ACK, so the
   // registered outputs appear during CAPTURE.
   assign w_capture  = (r_state == ST_ACK) && eoc_p;
   assign w_counting = (r_state == ST_READY) || (r_state == ST_REQ) ||
                       (r_state == ST_ACK)   || (r_state == ST_GAP);

   // The first sample after reset has no predecessor and never counts as
   // an unchanged step.
   always_comb begin
      w_stall_next = '0;
      if (w_same && r_have_prev) begin
         w_stall_next = (r_stall_cnt == '1) ? r_stall_cnt
                                            : r_stall_cnt + c_STALL_W'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state        <= ST_IDLE;
         r_cnt          <= '0;
         r_soc_p        <= 1'b0;
         r_x_last       <= '0;
         r_y_last       <= '0;
         r_dx           <= '0;
         r_dy           <= '0;
         r_sample_valid <= 1'b0;
         r_n_samples    <= '0;
         r_stalled      <= 1'b0;
         r_timeout      <= 1'b0;
         r_have_prev    <= 1'b0;
         r_stall_cnt    <= '0;
      end else begin
         r_state        <= w_next_state;
         r_cnt          <= (w_counting && (w_next_state == r_state))
                           ? r_cnt + c_CNT_W'(1) : '0;
         // soc_p is registered from the next state so it is high exactly
         // while the FSM sits in REQ.
         r_soc_p        <= (w_next_state == ST_REQ);
         r_sample_valid <= w_capture;
         if (w_abort) r_timeout <= 1'b1;
         if (w_capture) begin
            r_x_last    <= x;
            r_y_last    <= y;
            r_dx        <= r_have_prev ? w_dx : '0;
            r_dy        <= r_have_prev ? w_dy : '0;
            r_have_prev <= 1'b1;
            if (r_n_samples != 8'hFF) r_n_samples <= r_n_samples + 8'd1;
            r_stall_cnt <= w_stall_next;
            r_stalled   <= (w_stall_next >= c_STALL_LIM);
         end
      end
   end

   assign soc_p        = r_soc_p;
   assign x_last       = r_x_last;
   assign y_last       = r_y_last;
   assign dx           = r_dx;
   assign dy           = r_dy;
   assign sample_valid = r_sample_valid;
   assign n_samples    = r_n_samples;
   assign stalled      = r_stalled;
   assign timeout      = r_timeout;

endmodule
`default_nettype wire
